la_iddr_align: RTL and testbench

Word-alignment controller and deserializer for a single `la_iddr` input lane. It consumes the per-cycle rise/fall sample pair and assembles it into WIDTH-bit words. Its training state machine slips the word boundary one bit at a time until a known training pattern is found, then delivers aligned words over a valid/ready handshake. It sits between the `la_iddr` pad cell and the link or PHY receive logic.

---
 rtl/la_iddr_align.sv | 221 ++++++++++++++++++++++
 tb/tb_la_iddr_align.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_iddr_align.sv
// la_iddr_align: word-alignment controller and deserializer for one la_iddr lane.
// Rise/fall pairs shift into a 2*WIDTH history register. A WIDTH-bit word is cut
// from it every WIDTH/2 cycles at the current bit offset (slip).
// Optional feature macro: LA_IDDR_ALIGN_EN compiles in the training FSM, which
// slips the word boundary until PATTERN is seen LOCKCNT times in a row. Without
// the macro, the lane locks as soon as it is enabled, with a fixed offset of zero.
module la_iddr_align #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = 8'hB4,
  parameter int               LOCKCNT = 4,
  parameter                   PROP    = "DEFAULT"
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     enable,
  input  logic                     train,
  input  logic                     rise,
  input  logic                     fall,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     locked,
  output logic                     align_err,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [$clog2(WIDTH)-1:0] slip
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH / 2);
  localparam int TW = $clog2(WIDTH) + 1;
  localparam int MW = $clog2(LOCKCNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_VERIFY = 3'd3,
    ST_LOCK   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t             state_r;
  logic [2*WIDTH-1:0] h_r;
  logic [2*WIDTH-1:0] h_next_s;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_valid_r;
  logic               overflow_r;
  logic               locked_r;
  logic [SW-1:0]      slip_s;
  logic [SW:0]        base_s;
  logic               train_win_s;
  logic               boundary_s;
  logic [WIDTH-1:0]   word_s;
  logic               deliver_s;
  logic               drop_s;
  logic               unused_s;

  // History including this cycle's pair; rise is the older bit so it lands higher.
  assign h_next_s   = {h_r[2*WIDTH-3:0], rise, fall};
  assign boundary_s = enable && (cnt_r == CNT_LAST);
  assign base_s     = {1'b0, slip_s};
  assign word_s     = h_next_s[base_s +: WIDTH];
  // A train pulse pre-empts the boundary, so no word is produced in that cycle.
  assign deliver_s  = boundary_s && (state_r == ST_LOCK) && !train_win_s;
  assign drop_s     = deliver_s && out_valid_r && !out_ready;
  assign unused_s   = ^{train, h_r[2*WIDTH-1 -: 2], PROP};

  // Shift history and run the phase counter while enabled; history survives disable.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      h_r   <= {(2*WIDTH){1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (!enable) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      h_r   <= h_next_s;
      cnt_r <= (cnt_r == CNT_LAST) ? {CW{1'b0}} : cnt_r + 1'b1;
    end
  end

  // Output word register with valid/ready handshake and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (!enable) begin
        out_valid_r <= 1'b0;
      end else if (deliver_s && !drop_s) begin
        out_data_r  <= word_s;
        out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Lock indicator follows the state one cycle late.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      locked_r <= 1'b0;
    end else begin
      locked_r <= (state_r == ST_LOCK);
    end
  end

`ifdef LA_IDDR_ALIGN_EN
  logic [SW-1:0] slip_r;
  logic [TW-1:0] tries_r;
  logic [MW-1:0] match_r;
  logic          align_err_r;
  logic          hit_s;
  logic [SW-1:0] slip_inc_s;

  assign hit_s       = (word_s == PATTERN);
  assign slip_inc_s  = (slip_r == SW'(WIDTH - 1)) ? {SW{1'b0}} : slip_r + 1'b1;
  assign slip_s      = slip_r;
  assign train_win_s = train;
  assign align_err   = align_err_r;

  // Training FSM: slip one bit per failed boundary, verify repeats, then lock.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
      slip_r  <= {SW{1'b0}};
      tries_r <= {TW{1'b0}};
      match_r <= {MW{1'b0}};
    end else if (!enable) begin
      state_r <= ST_IDLE;
      tries_r <= {TW{1'b0}};
      match_r <= {MW{1'b0}};
    end else if (train) begin
      state_r <= ST_SEARCH;
      tries_r <= {TW{1'b0}};
      match_r <= {MW{1'b0}};
    end else begin
      case (state_r)
        ST_SEARCH: begin
          if (tries_r == TW'(WIDTH)) begin
            state_r <= ST_ERROR;
          end else if (boundary_s && hit_s) begin
            if (LOCKCNT == 1) begin
              state_r <= ST_LOCK;
            end else begin
              state_r <= ST_VERIFY;
              match_r <= MW'(1);
            end
          end else if (boundary_s) begin
            slip_r  <= slip_inc_s;
            tries_r <= tries_r + 1'b1;
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (boundary_s) state_r <= ST_SEARCH;
        end
        ST_VERIFY: begin
          if (boundary_s && hit_s) begin
            match_r <= match_r + 1'b1;
            if (match_r == MW'(LOCKCNT - 1)) state_r <= ST_LOCK;
          end else if (boundary_s) begin
            slip_r  <= slip_inc_s;
            tries_r <= tries_r + 1'b1;
            state_r <= ST_SETTLE;
          end
        end
        ST_IDLE, ST_LOCK, ST_ERROR: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Alignment error indicator follows the state one cycle late.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      align_err_r <= 1'b0;
    end else begin
      align_err_r <= (state_r == ST_ERROR);
    end
  end
`else
  assign slip_s      = {SW{1'b0}};
  assign train_win_s = 1'b0;
  assign align_err   = 1'b0;

  // Without training the lane is locked whenever it is enabled.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
    end else if (!enable) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= ST_LOCK;
    end
  end
`endif

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign overflow  = overflow_r;
  assign locked    = locked_r;
  assign slip      = slip_s;

endmodule

// File: tb/tb_la_iddr_align.sv
// Self-checking bench for la_iddr_align (WIDTH=8, PATTERN=8'hB4, LOCKCNT=4).
// A stream-level reference model (received bits kept in a queue, words cut by
// offset arithmetic) is stepped every clock and compared to every output.
module tb_la_iddr_align;
  localparam int W    = 8;
  localparam int HALF = W / 2;
  localparam int LC   = 4;
  localparam logic [W-1:0] PAT = 8'hB4;
`ifdef LA_IDDR_ALIGN_EN
  localparam bit FSM = 1'b1;
`else
  localparam bit FSM = 1'b0;
`endif
  localparam int M_IDLE = 0, M_SEARCH = 1, M_SETTLE = 2, M_VERIFY = 3, M_LOCK = 4, M_ERROR = 5;

  logic clk = 1'b0;
  logic nreset, enable, train, rise, fall, out_ready, ovf_clr;
  logic [W-1:0] out_data;
  logic out_valid, locked, align_err, overflow;
  logic [$clog2(W)-1:0] slip;

  la_iddr_align #(.WIDTH(W), .PATTERN(PAT), .LOCKCNT(LC), .PROP("DEFAULT")) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .train(train),
    .rise(rise), .fall(fall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .locked(locked), .align_err(align_err),
    .overflow(overflow), .ovf_clr(ovf_clr), .slip(slip)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // stream source: 0 random, 1 repeating pattern advanced by dly bits, 2 zeros
  int src = 0;
  int dly = 0;
  int nbit = 0;

  // reference model state
  bit m_stream[$];
  int m_ph, m_st, m_slip, m_tries, m_match;
  logic [W-1:0] m_data;
  bit m_valid, m_ovf, m_locked, m_aerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gen_bit();
    logic b;
    logic [W-1:0] pv;
    pv = PAT;
    case (src)
      1:       b = pv[W-1 - ((nbit + dly) % W)];
      2:       b = 1'b0;
      default: b = 1'($urandom_range(0, 1));
    endcase
    nbit++;
    return b;
  endfunction

  // Word at the current offset: bit k is the bit received slip+k bits before the newest.
  function automatic logic [W-1:0] m_word();
    logic [W-1:0] w;
    int n;
    n = m_stream.size();
    for (int k = 0; k < W; k++) w[k] = m_stream[n - 1 - m_slip - k];
    return w;
  endfunction

  task automatic model_step();
    bit bnd, deliver, drop, hit;
    logic [W-1:0] w;
    int st0;
    if (!nreset) begin
      m_stream.delete();
      for (int i = 0; i < 2 * W; i++) m_stream.push_back(1'b0);
      m_ph = 0; m_st = M_IDLE; m_slip = 0; m_tries = 0; m_match = 0;
      m_data = '0; m_valid = 0; m_ovf = 0; m_locked = 0; m_aerr = 0;
      return;
    end
    st0 = m_st;
    m_locked = (st0 == M_LOCK);
    m_aerr = FSM && (st0 == M_ERROR);
    if (!enable) begin
      m_ph = 0; m_valid = 0; m_st = M_IDLE; m_tries = 0; m_match = 0;
      if (ovf_clr) m_ovf = 0;
      return;
    end
    m_stream.push_back(rise);
    m_stream.push_back(fall);
    while (m_stream.size() > 2 * W) void'(m_stream.pop_front());
    bnd = (m_ph == HALF - 1);
    m_ph = (m_ph + 1) % HALF;
    w = m_word();
    hit = (w == PAT);
    deliver = bnd && (st0 == M_LOCK) && !(FSM && train);
    drop = deliver && m_valid && !out_ready;
    if (deliver && !drop) begin
      m_data = w; m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    if (!FSM) begin
      m_st = M_LOCK;
    end else if (train) begin
      m_st = M_SEARCH; m_tries = 0; m_match = 0;
    end else begin
      case (st0)
        M_SEARCH:
          if (m_tries == W) m_st = M_ERROR;
          else if (bnd && hit) begin
            if (LC == 1) m_st = M_LOCK;
            else begin m_st = M_VERIFY; m_match = 1; end
          end else if (bnd) begin
            m_slip = (m_slip + 1) % W; m_tries++; m_st = M_SETTLE;
          end
        M_SETTLE: if (bnd) m_st = M_SEARCH;
        M_VERIFY:
          if (bnd && hit) begin
            m_match++;
            if (m_match == LC) m_st = M_LOCK;
          end else if (bnd) begin
            m_slip = (m_slip + 1) % W; m_tries++; m_st = M_SETTLE;
          end
        default: m_st = st0;
      endcase
    end
  endtask

  // One clock: drive the pair, step the model at the edge, compare on the falling edge.
  task automatic cyc();
    if (enable && nreset) begin
      rise = gen_bit();
      fall = gen_bit();
    end else begin
      rise = 1'($urandom_range(0, 1));
      fall = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cyc_data", out_data, m_data);
    chk("cyc_valid", out_valid, m_valid);
    chk("cyc_locked", locked, m_locked);
    chk("cyc_align_err", align_err, m_aerr);
    chk("cyc_overflow", overflow, m_ovf);
    chk("cyc_slip", slip, m_slip);
  endtask

  initial begin
    nreset = 0; enable = 0; train = 0; rise = 0; fall = 0; out_ready = 1; ovf_clr = 0;

    // reset with a random stream
    repeat (3) cyc();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_align_err", align_err, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_slip", slip, 0);
    nreset = 1;
    repeat (4) cyc();
    chk("idle_no_valid", out_valid, 0);
    chk("idle_unlocked", locked, 0);

    // bit-aligned pattern stream, enable and train together
    src = 1; dly = 0; nbit = 0; enable = 1; train = 1;
    cyc();
    train = 0;
    for (int i = 0; i < 100 && !locked; i++) cyc();
    chk("lock_aligned", locked, 1);
    chk("slip_aligned", slip, 0);
    for (int i = 0; i < 20 && !out_valid; i++) cyc();
    chk("word_aligned_valid", out_valid, 1);
    chk("word_aligned", out_data, PAT);
    repeat (3) cyc();
    chk("gap_valid_low", out_valid, 0);
    cyc();
    chk("next_word_valid", out_valid, 1);
    chk("next_word", out_data, PAT);

    // backpressure: word held, later words dropped
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("held_data", out_data, PAT);
      chk("held_valid", out_valid, 1);
    end
    chk("ovf_set", overflow, 1);
    ovf_clr = 1; out_ready = 1;
    cyc();
    ovf_clr = 0;
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 10 && !out_valid; i++) cyc();
    chk("resume_valid", out_valid, 1);
    chk("resume_data", out_data, PAT);

    // train while locked
    train = 1;
    cyc();
    train = 0;
    cyc();
`ifdef LA_IDDR_ALIGN_EN
    chk("train_unlocks", locked, 0);
    chk("train_keeps_slip", slip, 0);
    for (int i = 0; i < 100 && !locked; i++) cyc();
    chk("relock", locked, 1);
`else
    chk("train_ignored", locked, 1);
`endif

    // reset mid-operation with a pending word
    out_ready = 0;
    for (int i = 0; i < 10 && !out_valid; i++) cyc();
    chk("pre_reset_valid", out_valid, 1);
    nreset = 0;
    cyc();
    nreset = 1; out_ready = 1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_locked", locked, 0);
    chk("rst_mid_slip", slip, 0);
    chk("rst_mid_overflow", overflow, 0);

    // stream offset by 3 bits
    enable = 0;
    cyc();
    src = 1; dly = 3; nbit = 0; enable = 1; train = 1;
    cyc();
    train = 0;
    for (int i = 0; i < 300 && !locked; i++) cyc();
    chk("lock_delayed", locked, 1);
    chk("slip_delayed", slip, FSM ? 3 : 0);
    for (int i = 0; i < 20 && !out_valid; i++) cyc();
    chk("word_delayed_valid", out_valid, 1);
    // untrained lane sees 8'hB4 rotated left by 3
    chk("word_delayed", out_data, FSM ? PAT : 8'hA5);

`ifdef LA_IDDR_ALIGN_EN
    // constant-zero stream exhausts every offset
    enable = 0;
    cyc();
    src = 2; enable = 1; train = 1;
    cyc();
    train = 0;
    for (int i = 0; i < 300 && !align_err; i++) cyc();
    chk("align_err_set", align_err, 1);
    chk("align_err_unlocked", locked, 0);
    train = 1;
    cyc();
    train = 0;
    cyc();
    chk("align_err_cleared", align_err, 0);
`endif

    // randomized traffic against the model
    src = 0;
    for (int i = 0; i < 400; i++) begin
      nreset    = ($urandom_range(0, 99) != 0);
      enable    = ($urandom_range(0, 24) != 0);
      train     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
